// File: rtl/shift_pkg.sv
// Shared definitions for the iterative left shifter.
// Holds the default datapath widths, the FSM state encoding and the
// per-cycle step sizes used by shl_step.
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam int STEP1 = 1;
  localparam int STEP4 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_t;

endpackage

// File: rtl/shift_left_iter_if.sv
// Request/result bundle for shift_left_iter.
//   start : request pulse, sampled only while busy=0
//   A     : operand to shift
//   B     : shift amount
//   busy  : high while a shift is in progress
//   done  : one-cycle pulse marking out as the fresh result
//   out   : registered result A << B, held until the next done
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0 (that is, in IDLE or in the DONE cycle). A and B are sampled only
// on that edge. done pulses for exactly one cycle per accepted request, and
// out stays stable from that cycle until the next done.
interface shift_left_iter_if #(
  parameter int WIDTH   = shift_pkg::WIDTH,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] B;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;

  modport master (output start, output A, output B,
                  input busy, input done, input out);
  modport slave  (input start, input A, input B,
                  output busy, output done, output out);
endinterface

// File: rtl/shift_left_iter_shl_step.sv
// shl_step: combinational single-step left shifter.
// Given the running accumulator and remaining count, returns the next
// accumulator and count, plus 'last' when this step finishes the shift.
// Build option SHL_STEP4_EN: when defined, steps of 4 are taken while
// cnt >= 4; otherwise (default) every step shifts by 1.
//   acc      : current partial result
//   cnt      : remaining shift amount (nonzero while shifting)
//   acc_nxt  : accumulator after this step
//   cnt_nxt  : remaining count after this step
//   last     : cnt_nxt == 0
module shl_step #(
  parameter int WIDTH   = shift_pkg::WIDTH,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [SHAMT_W-1:0] cnt,
  output logic [WIDTH-1:0]   acc_nxt,
  output logic [SHAMT_W-1:0] cnt_nxt,
  output logic               last
);
  import shift_pkg::*;

  always_comb begin
    acc_nxt = acc << STEP1;
    cnt_nxt = cnt - SHAMT_W'(STEP1);
`ifdef SHL_STEP4_EN
    // Coarse steps first; the final 0..3 bits fall back to single steps.
    if (cnt >= SHAMT_W'(STEP4)) begin
      acc_nxt = acc << STEP4;
      cnt_nxt = cnt - SHAMT_W'(STEP4);
    end
`endif
    last = (cnt_nxt == '0);
  end

endmodule

// File: rtl/shift_left_iter.sv
// shift_left_iter: iterative logical left shifter (SLL/SLLI datapath).
// Computes A << B over several cycles with zero fill from the LSB; bits
// shifted past the MSB are dropped. Build option SHL_STEP4_EN (see
// shl_step) shortens latency by taking 4-bit steps.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high; wins over a simultaneous start
//   bus       : shift_left_iter_if slave (start/A/B in, busy/done/out out)
//   state_dbg : current FSM state, for observation only
module shift_left_iter #(
  parameter int WIDTH   = shift_pkg::WIDTH,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_left_iter_if.slave       bus,
  output shift_pkg::shl_state_t  state_dbg
);
  import shift_pkg::*;

  shl_state_t         state, state_nxt;
  logic [WIDTH-1:0]   acc, out_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   step_acc;
  logic [SHAMT_W-1:0] step_cnt;
  logic               step_last;
  logic               accept;
  logic               busy_c, done_c;

  shl_step #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_step (
    .acc     (acc),
    .cnt     (cnt),
    .acc_nxt (step_acc),
    .cnt_nxt (step_cnt),
    .last    (step_last)
  );

  // A request is taken whenever the shifter is not mid-operation, which
  // lets a new start in the DONE cycle run back-to-back.
  assign accept = bus.start && (state != SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (bus.B == '0) ? DONE : SHIFT;
        else        state_nxt = IDLE;
      end
      SHIFT: begin
        if (step_last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so nothing on the request
  // side reaches busy/done combinationally.
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    unique case (state)
      SHIFT:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath. out_q is loaded on the edge that enters DONE so the result
  // is visible in the done cycle and survives a back-to-back reload of acc.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      out_q <= '0;
    end else if (accept) begin
      acc <= bus.A;
      cnt <= bus.B;
      if (bus.B == '0) out_q <= bus.A;
    end else if (state == SHIFT) begin
      acc <= step_acc;
      cnt <= step_cnt;
      if (step_last) out_q <= step_acc;
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.out   = out_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_left_iter.sv
// Directed bench for shift_left_iter. Expected results and latencies are
// hand-computed; the latency table follows the SHL_STEP4_EN build option.
module tb_shift_left_iter;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  shift_left_iter_if bus ();
  shl_state_t state_dbg;

  shift_left_iter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle; afterwards we sit in cycle c+1.
  task automatic launch(input logic [31:0] a, input logic [4:0] b, input logic [31:0] exp_out);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(exp_out);
    tick();
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = 5'($urandom_range(0, 31));
    cyc = 1;
  endtask

  // Wait (bounded) for done, confirming busy stays high meanwhile, then
  // check latency and the result against the scoreboard queue.
  task automatic wait_done(input string tag, input int exp_lat);
    logic [31:0] exp_out;
    bit busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    exp_out = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_busy_until_done"}, 32'(busy_ok), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_out"}, bus.out, exp_out);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask

`ifdef SHL_STEP4_EN
  localparam int LAT_B31 = 11, LAT_B4 = 2, LAT_B8 = 3, LAT_B2 = 3,
                 LAT_B16 = 5, LAT_B7 = 5, LAT_B1 = 2;
`else
  localparam int LAT_B31 = 32, LAT_B4 = 5, LAT_B8 = 9, LAT_B2 = 3,
                 LAT_B16 = 17, LAT_B7 = 8, LAT_B1 = 2;
`endif

  // ---------------- directed sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset for two cycles
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out",   bus.out, 32'h0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // B=0: done in c+1
    launch(32'h0000_0001, 5'd0, 32'h0000_0001);
    wait_done("b0", 1);
    tick();
    check("b0_idle_done", 32'(bus.done), 32'd0);
    check("b0_hold_out", bus.out, 32'h0000_0001);

    // Maximum shift
    launch(32'h0000_0001, 5'd31, 32'h8000_0000);
    wait_done("b31", LAT_B31);
    tick();

    // High bits discarded
    launch(32'hF000_000F, 5'd4, 32'h0000_00F0);
    wait_done("b4", LAT_B4);
    tick();

    // Assorted patterns
    launch(32'h8000_0001, 5'd1, 32'h0000_0002);
    wait_done("b1", LAT_B1);
    tick();
    launch(32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000);
    wait_done("b16", LAT_B16);
    tick();
    launch(32'h0000_0001, 5'd7, 32'h0000_0080);
    wait_done("b7", LAT_B7);
    tick();

    // Start while busy is ignored
    launch(32'h1234_5678, 5'd8, 32'h3456_7800);
    check("mid_busy_c1", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 5'd1;
    tick();
    cyc++;
    bus.start = 1'b0;
    wait_done("mid", LAT_B8);

    // Back-to-back: new start in the DONE cycle
    launch(32'h0000_0003, 5'd2, 32'h0000_000C);
    check("b2b_busy_next", 32'(bus.busy), 32'd1);
    check("b2b_out_held", bus.out, 32'h3456_7800);
    wait_done("b2b", LAT_B2);
    tick();
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);
    check("b2b_idle_out", bus.out, 32'h0000_000C);

    // Reset at c+5 of a B=20 shift
    launch(32'h0000_0001, 5'd20, 32'h0);
    void'(exp_q.pop_back());
    while (cyc < 5) begin
      tick();
      cyc++;
    end
    check("rmid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_out",  bus.out, 32'h0);
    check("rmid_busy", 32'(bus.busy), 32'd0);
    check("rmid_done", 32'(bus.done), 32'd0);
    begin
      bit saw_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
        tick();
        if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("rmid_no_done", 32'(saw_done), 32'd0);
    end

    // Reset and start together: reset wins
    bus.start = 1'b1;
    bus.A     = 32'hAAAA_5555;
    bus.B     = 5'd0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rs_busy", 32'(bus.busy), 32'd0);
    check("rs_done", 32'(bus.done), 32'd0);
    tick();
    check("rs_done_after", 32'(bus.done), 32'd0);
    check("rs_out", bus.out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
